// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: parity modes, receiver FSM encoding and a
// constant-safe clog2 helper, kept here so the TX successor can reuse them.
package uart_rx_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // Bits needed to hold values 0..value-1 (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Consumer-side bundle of the UART receiver: head word, error flags, sticky
// status and the pop / interrupt-clear controls.
interface uart_rx_param_if
  import uart_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = clog2(FIFO_DEPTH + 1);

  logic              rd_en;
  logic              clearInterrupt;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              parityError;
  logic              frameError;
  logic              overrun;
  logic              rxInterrupt;
  logic [CW-1:0]     fifo_count;

  modport master (
    input  rd_en, clearInterrupt,
    output rx_data, rx_valid, parityError, frameError, overrun, rxInterrupt, fifo_count
  );

  modport slave (
    output rd_en, clearInterrupt,
    input  rx_data, rx_valid, parityError, frameError, overrun, rxInterrupt, fifo_count
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through buffer: dout always shows the oldest entry, and a
// push is accepted while full when a pop happens in the same cycle.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic                        rd_en,
  input  logic [WIDTH-1:0]            din,
  output logic [WIDTH-1:0]            dout,
  output logic                        valid,
  output logic                        full,
  output logic [clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             pop, push;

  assign valid = (count_reg != '0);
  assign full  = (count_reg == CW'(DEPTH));
  assign pop   = rd_en & valid;
  assign push  = wr_en & (~full | pop);
  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with per-word parity/stop error flags.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry buffer; otherwise one holding register.
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_W       = 8,
  parameter int PARITY_MODE  = PAR_NONE,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            serialDataRX,
  uart_rx_param_if.master bus
);
  localparam int BAUD_W = clog2(CLKS_PER_BIT);
  localparam int BIT_W  = clog2(DATA_W + 1);
  localparam int CW     = clog2(FIFO_DEPTH + 1);
  localparam int WORD_W = DATA_W + 2;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  logic sync1_reg, sync2_reg, prev_reg;
  rx_state_e state_reg, state_next;
  logic [BAUD_W-1:0] baud_reg, baud_next;
  logic [BIT_W-1:0]  bit_reg, bit_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic perr_reg, perr_next, ferr_reg, ferr_next;
  logic push, sample;
  logic [WORD_W-1:0] push_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
    end else begin
      sync1_reg <= serialDataRX;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      perr_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      perr_reg  <= perr_next;
      ferr_reg  <= ferr_next;
    end
  end

  assign sample = (baud_reg == BAUD_LAST);
  // The last stop sample is folded in directly so the word can be pushed that cycle.
  assign push_word = {ferr_reg | ~sync2_reg, perr_reg, shift_reg};

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg + 1'b1;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    perr_next  = perr_reg;
    ferr_next  = ferr_reg;
    push       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        baud_next = '0;
        if (prev_reg & ~sync2_reg) state_next = ST_START;
      end
      ST_START: begin
        if (baud_reg == BAUD_HALF) begin
          baud_next = '0;
          if (sync2_reg) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_DATA;
            bit_next   = '0;
            perr_next  = 1'b0;
            ferr_next  = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (sample) begin
          baud_next  = '0;
          shift_next = {sync2_reg, shift_reg[DATA_W-1:1]};
          bit_next   = bit_reg + 1'b1;
          if (bit_reg == DATA_LAST) begin
            bit_next   = '0;
            state_next = (PARITY_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (sample) begin
          baud_next  = '0;
          perr_next  = ((^shift_reg) ^ sync2_reg) != (PARITY_MODE == PAR_ODD);
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample) begin
          baud_next = '0;
          ferr_next = ferr_reg | ~sync2_reg;
          if (bit_reg == STOP_LAST) begin
            push       = 1'b1;
            state_next = ST_IDLE;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  logic [WORD_W-1:0] head_word;
  logic              buf_valid, buf_full;
  logic [CW-1:0]     buf_count;

`ifdef UART_RX_FIFO_EN
  uart_rx_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .wr_en(push), .rd_en(bus.rd_en), .din(push_word),
    .dout(head_word), .valid(buf_valid), .full(buf_full), .count(buf_count)
  );
`else
  logic              hold_valid_reg;
  logic [WORD_W-1:0] hold_word_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_reg <= 1'b0;
      hold_word_reg  <= '0;
    end else if (push && (!hold_valid_reg || bus.rd_en)) begin
      hold_valid_reg <= 1'b1;
      hold_word_reg  <= push_word;
    end else if (bus.rd_en) begin
      hold_valid_reg <= 1'b0;
    end
  end

  assign head_word = hold_word_reg;
  assign buf_valid = hold_valid_reg;
  assign buf_full  = hold_valid_reg;
  assign buf_count = CW'(hold_valid_reg);
`endif

  logic intr_reg, ovr_reg;

  // A set in the same cycle as clearInterrupt takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      intr_reg <= 1'b0;
      ovr_reg  <= 1'b0;
    end else begin
      if (push)                     intr_reg <= 1'b1;
      else if (bus.clearInterrupt)  intr_reg <= 1'b0;
      if (push && buf_full && !bus.rd_en) ovr_reg <= 1'b1;
      else if (bus.clearInterrupt)        ovr_reg <= 1'b0;
    end
  end

  assign bus.rx_data     = buf_valid ? head_word[DATA_W-1:0] : '0;
  assign bus.parityError = buf_valid & head_word[DATA_W];
  assign bus.frameError  = buf_valid & head_word[DATA_W+1];
  assign bus.rx_valid    = buf_valid;
  assign bus.fifo_count  = buf_count;
  assign bus.overrun     = ovr_reg;
  assign bus.rxInterrupt = intr_reg;
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three receivers (8N1, 8E1, 7O2) driven bit-accurately,
// checked against a queue model of the receive buffer and its sticky flags.
module tb_uart_rx_param;
  import uart_rx_pkg::*;

  localparam int CPB = 16;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  localparam int DW [3] = '{8, 8, 7};
  localparam int PM [3] = '{PAR_NONE, PAR_EVEN, PAR_ODD};
  localparam int SB [3] = '{1, 1, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ser0 = 1'b1, ser1 = 1'b1, ser2 = 1'b1;
  always #5 clk = ~clk;

  uart_rx_param_if #(.DATA_W(8), .FIFO_DEPTH(4)) if0 ();
  uart_rx_param_if #(.DATA_W(8), .FIFO_DEPTH(4)) if1 ();
  uart_rx_param_if #(.DATA_W(7), .FIFO_DEPTH(4)) if2 ();

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_MODE(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4))
    u0 (.clk(clk), .rst(rst), .serialDataRX(ser0), .bus(if0));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_MODE(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(4))
    u1 (.clk(clk), .rst(rst), .serialDataRX(ser1), .bus(if1));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_W(7), .PARITY_MODE(PAR_ODD), .STOP_BITS(2), .FIFO_DEPTH(4))
    u2 (.clk(clk), .rst(rst), .serialDataRX(ser2), .bus(if2));

  int checks = 0, passes = 0, fails = 0;

  // Model: per receiver a ring of {ferr, perr, data} words plus sticky flags.
  int m_word [3][8];
  int m_head [3];
  int m_cnt  [3];
  bit m_ovr  [3];
  bit m_int  [3];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_head[i] = 0; m_cnt[i] = 0; m_ovr[i] = 1'b0; m_int[i] = 1'b0;
    end
  endtask

  task automatic m_pop(input int i);
    if (m_cnt[i] > 0) begin
      m_head[i] = (m_head[i] + 1) % 8;
      m_cnt[i]--;
    end
  endtask

  task automatic m_push(input int i, input int w, input bit rd);
    if (rd) m_pop(i);
    if (m_cnt[i] < DEPTH) begin
      m_word[i][(m_head[i] + m_cnt[i]) % 8] = w;
      m_cnt[i]++;
    end else begin
      m_ovr[i] = 1'b1;
    end
    m_int[i] = 1'b1;
  endtask

  task automatic check_state(input int i, input string tag);
    logic v, pe, fe, ov, it;
    logic [15:0] d, cnt, hw;
    case (i)
      0: begin v = if0.rx_valid; d = 16'(if0.rx_data); pe = if0.parityError; fe = if0.frameError;
               cnt = 16'(if0.fifo_count); ov = if0.overrun; it = if0.rxInterrupt; end
      1: begin v = if1.rx_valid; d = 16'(if1.rx_data); pe = if1.parityError; fe = if1.frameError;
               cnt = 16'(if1.fifo_count); ov = if1.overrun; it = if1.rxInterrupt; end
      default: begin v = if2.rx_valid; d = 16'(if2.rx_data); pe = if2.parityError; fe = if2.frameError;
               cnt = 16'(if2.fifo_count); ov = if2.overrun; it = if2.rxInterrupt; end
    endcase
    hw = (m_cnt[i] > 0) ? 16'(m_word[i][m_head[i]]) : 16'h0;
    chk($sformatf("%s.rx_valid", tag),    16'(v),   16'(m_cnt[i] > 0));
    chk($sformatf("%s.rx_data", tag),     d,        {7'h0, hw[8:0]});
    chk($sformatf("%s.parityError", tag), 16'(pe),  16'(hw[9]));
    chk($sformatf("%s.frameError", tag),  16'(fe),  16'(hw[10]));
    chk($sformatf("%s.fifo_count", tag),  cnt,      16'(m_cnt[i]));
    chk($sformatf("%s.overrun", tag),     16'(ov),  16'(m_ovr[i]));
    chk($sformatf("%s.rxInterrupt", tag), 16'(it),  16'(m_int[i]));
  endtask

  task automatic drive_line(input int i, input logic v);
    case (i)
      0: ser0 = v;
      1: ser1 = v;
      default: ser2 = v;
    endcase
  endtask

  function automatic logic good_par(input int i, input int data);
    logic [8:0] d;
    d = 9'(data & ((1 << DW[i]) - 1));
    return (^d) ^ (PM[i] == PAR_ODD);
  endfunction

  // Must be called on a falling clock edge. With rd_pulse, receiver 0's rd_en is
  // raised for the push cycle: 11 clocks into the last stop bit (2 synchroniser
  // stages + edge detect + half a bit).
  task automatic send_frame(input int i, input int data, input logic par,
                            input logic [1:0] stops, input bit rd_pulse);
    logic [15:0] bits;
    logic [8:0]  d;
    int n;
    bit perr, ferr;
    d = 9'(data & ((1 << DW[i]) - 1));
    bits = '0;
    n = 1;
    for (int k = 0; k < DW[i]; k++) begin bits[n] = d[k]; n++; end
    if (PM[i] != PAR_NONE) begin bits[n] = par; n++; end
    for (int s = 0; s < SB[i]; s++) begin bits[n] = stops[s]; n++; end
    for (int b = 0; b < n; b++) begin
      drive_line(i, bits[b]);
      for (int c = 0; c < CPB; c++) begin
        if (rd_pulse) if0.rd_en = (b == n - 1) && (c == 11);
        @(negedge clk);
      end
    end
    if0.rd_en = 1'b0;
    if (bits[n-1] == 1'b0) begin
      drive_line(i, 1'b1);
      repeat (CPB) @(negedge clk);
    end
    perr = (PM[i] != PAR_NONE) && (((^d) ^ par) != (PM[i] == PAR_ODD));
    ferr = (stops[0] == 1'b0) || (SB[i] == 2 && stops[1] == 1'b0);
    m_push(i, int'(d) | (int'(perr) << 9) | (int'(ferr) << 10), rd_pulse);
    $display("frame rx%0d data=%0h par=%0b stops=%b rd=%0b", i, d, par, stops, rd_pulse);
  endtask

  task automatic pop(input int i);
    case (i)
      0: if0.rd_en = 1'b1;
      1: if1.rd_en = 1'b1;
      default: if2.rd_en = 1'b1;
    endcase
    @(negedge clk);
    if0.rd_en = 1'b0; if1.rd_en = 1'b0; if2.rd_en = 1'b0;
    m_pop(i);
  endtask

  task automatic clear_int(input int i);
    case (i)
      0: if0.clearInterrupt = 1'b1;
      1: if1.clearInterrupt = 1'b1;
      default: if2.clearInterrupt = 1'b1;
    endcase
    @(negedge clk);
    if0.clearInterrupt = 1'b0; if1.clearInterrupt = 1'b0; if2.clearInterrupt = 1'b0;
    m_int[i] = 1'b0;
    m_ovr[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    for (int k = 0; k < 8; k++) if (m_cnt[i] > 0) pop(i);
    clear_int(i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int data;
    logic [1:0] st;
    if0.rd_en = 1'b0; if1.rd_en = 1'b0; if2.rd_en = 1'b0;
    if0.clearInterrupt = 1'b0; if1.clearInterrupt = 1'b0; if2.clearInterrupt = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_state(i, $sformatf("reset%0d", i));
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 basic receive, pop, pop on empty, interrupt clear
    send_frame(0, 'hA5, 1'b0, 2'b11, 1'b0);
    check_state(0, "t1_rx");
    pop(0);            check_state(0, "t1_pop");
    pop(0);            check_state(0, "t1_pop_empty");
    clear_int(0);      check_state(0, "t1_clear");

    // Even parity: bad then good parity bit on 0x07
    send_frame(1, 'h07, 1'b0, 2'b11, 1'b0);
    check_state(1, "t2_bad_par");
    pop(1);
    send_frame(1, 'h07, 1'b1, 2'b11, 1'b0);
    check_state(1, "t2_good_par");
    pop(1);

    // Two stop bits, second one low, then a clean frame
    send_frame(2, 'h3C, good_par(2, 'h3C), 2'b01, 1'b0);
    check_state(2, "t3_ferr");
    pop(2);
    send_frame(2, 'h55, good_par(2, 'h55), 2'b11, 1'b0);
    check_state(2, "t3_clean");
    drain(2);

    // Five back-to-back frames without reads: overrun, in-order pops, clear
    drain(0);
    for (int k = 0; k < 5; k++) send_frame(0, $urandom_range(0, 255), 1'b0, 2'b11, 1'b0);
    check_state(0, "t4_full");
    for (int k = 0; k < DEPTH; k++) begin
      check_state(0, $sformatf("t4_head%0d", k));
      pop(0);
    end
    check_state(0, "t4_empty");
    clear_int(0);      check_state(0, "t4_clear");

    // Short low glitch is rejected; receiver still takes the next frame
    drive_line(0, 1'b0);
    repeat (4) @(negedge clk);
    drive_line(0, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    check_state(0, "t5_glitch");
    send_frame(0, 'h3E, 1'b0, 2'b11, 1'b0);
    check_state(0, "t5_after_glitch");

    // Asynchronous reset in the middle of the data bits
    send_frame(1, 'h81, good_par(1, 'h81), 2'b11, 1'b0);
    drive_line(0, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    drive_line(0, 1'b1);
    m_reset();
    #1;
    check_state(0, "t5_async_rst0");
    check_state(1, "t5_async_rst1");
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send_frame(0, 'hC3, 1'b0, 2'b11, 1'b0);
    check_state(0, "t5_after_rst");
    drain(0);

    // Full buffer with a pop in the push cycle: no overrun, count unchanged
    for (int k = 0; k < DEPTH; k++) send_frame(0, $urandom_range(0, 255), 1'b0, 2'b11, 1'b0);
    check_state(0, "t6_full");
    send_frame(0, $urandom_range(0, 255), 1'b0, 2'b11, 1'b1);
    check_state(0, "t6_pop_push");
    drain(0);

    // Randomised traffic across all three receivers
    for (int it = 0; it < 12; it++) begin
      int i;
      logic par;
      i = it % 3;
      data = int'($urandom_range(0, 511));
      par = good_par(i, data) ^ ($urandom_range(0, 3) == 0);
      st = 2'b11;
      if ($urandom_range(0, 4) == 0) st[$urandom_range(0, SB[i] - 1)] = 1'b0;
      send_frame(i, data, par, st, 1'b0);
      check_state(i, $sformatf("rnd%0d", it));
      if ($urandom_range(0, 1) == 1) begin
        pop(i);
        check_state(i, $sformatf("rnd%0d_pop", it));
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
